instr_fetch_unit: RTL and testbench

- Upstream stage of the 16-bit CPU: owns the PC, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and presents one instruction at a time to the decode/control stage.
- `opcode` feeds the 3-bit control decoder.
- On consumption, it takes the decoder's `jump`/`branch` outputs and the ALU `zero` flag, and computes the next PC.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/next_pc_calc.sv | 25 ++
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: instruction field geometry, opcodes,
// fetch FSM state encoding and the branch-offset sign extension helper.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int JTGT_W  = 13;
    localparam int BOFS_W  = 7;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SLI  = 3'b010;
    localparam logic [2:0] OP_ROT  = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_LW   = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_ERR   = 2'b11
    } fetch_state_t;

    function automatic logic [INSTR_W-1:0] sext_bofs(input logic [BOFS_W-1:0] ofs);
        return {{(INSTR_W-BOFS_W){ofs[BOFS_W-1]}}, ofs};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target > taken branch > sequential.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] i_pc_plus1,
    input  logic [JTGT_W-1:0]  i_instr_lo,
    input  logic               i_jump,
    input  logic               i_branch,
    input  logic               i_alu_zero,
    output logic [INSTR_W-1:0] o_next_pc
);

    // Jump keeps the page bits of pc+1; branch offset is relative to pc+1.
    always_comb begin
        o_next_pc = i_pc_plus1;
        if (i_jump) begin
            o_next_pc = {i_pc_plus1[INSTR_W-1:JTGT_W], i_instr_lo};
        end else if (i_branch && i_alu_zero) begin
            o_next_pc = i_pc_plus1 + sext_bofs(i_instr_lo[BOFS_W-1:0]);
        end else begin
            o_next_pc = i_pc_plus1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, holds one
// instruction for decode and guards the memory handshake with a watchdog.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 16
)(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [2:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branch,
    input  logic        alu_zero,
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    output logic        fetch_err
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [15:0]  r_pc;
    logic [15:0]  r_instr;
    logic [15:0]  r_wd_cnt;
    logic         r_imem_req;
    logic         r_instr_valid;
    logic         r_fetch_err;
    logic [15:0]  w_pc_nxt;
    logic [15:0]  w_instr_nxt;
    logic [15:0]  w_wd_cnt_nxt;
    logic [15:0]  w_next_pc;
    logic [15:0]  w_pc_plus1;

    assign w_pc_plus1  = r_pc + 16'd1;
    assign pc_plus1    = w_pc_plus1;
    assign pc          = r_pc;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[OPC_MSB:OPC_LSB];
    assign imem_req    = r_imem_req;
    assign instr_valid = r_instr_valid;
    assign fetch_err   = r_fetch_err;

    next_pc_calc u_next_pc_calc (
        .i_pc_plus1 (w_pc_plus1),
        .i_instr_lo (r_instr[JTGT_W-1:0]),
        .i_jump     (jump),
        .i_branch   (branch),
        .i_alu_zero (alu_zero),
        .o_next_pc  (w_next_pc)
    );

    // Next-state and datapath update selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_wd_cnt_nxt = r_wd_cnt;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    w_instr_nxt  = imem_rdata;
                    w_wd_cnt_nxt = 16'd0;
                    w_state_nxt  = ST_HOLD;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + 16'd1;
                    if ((TIMEOUT != 0) && (r_wd_cnt == WD_LAST)) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    w_pc_nxt    = w_next_pc;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered handshake outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instr       <= 16'h0000;
            r_wd_cnt      <= 16'd0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_wd_cnt      <= w_wd_cnt_nxt;
            r_imem_req    <= (w_state_nxt == ST_FETCH);
            r_instr_valid <= (w_state_nxt == ST_HOLD);
            r_fetch_err   <= (w_state_nxt == ST_ERR);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: walks the PC through jumps, branches,
// sequential wrap, wait states, backpressure, watchdog and reset recovery.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic        branch;
    logic        alu_zero;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        fetch_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (16'h0010),
        .TIMEOUT  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .fetch_err   (fetch_err)
    );

    // Per step: instruction word, {jump,branch,alu_zero} on accept, ack wait cycles, expected next pc.
    logic [15:0] tv_instr [19] = '{16'h2005, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                                   16'hE123, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                   16'hFFFF, 16'h0000, 16'hE020, 16'h807E, 16'hE020, 16'h807E,
                                   16'h807E};
    logic [2:0]  tv_jbz   [19] = '{3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000,
                                   3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                   3'b100, 3'b000, 3'b100, 3'b011, 3'b100, 3'b010,
                                   3'b111};
    int          tv_waits [19] = '{0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] tv_next  [19] = '{16'h0011, 16'h1FFF, 16'h3FFF, 16'h4000, 16'h4001, 16'h4002,
                                   16'h4123, 16'h5FFF, 16'h7FFF, 16'h9FFF, 16'hBFFF, 16'hDFFF,
                                   16'hFFFF, 16'h0000, 16'h0020, 16'h001F, 16'h0020, 16'h0021,
                                   16'h007E};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 16'(imem_req), 16'd1);
    endtask

    task automatic fetch(input logic [15:0] exp_addr, input logic [15:0] data, input int waits);
        logic [2:0] exp_opc;
        exp_opc = data[15:13];
        wait_req();
        chk("addr", imem_addr, exp_addr);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("req_hold", 16'(imem_req), 16'd1);
            chk("addr_hold", imem_addr, exp_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        chk("valid", 16'(instr_valid), 16'd1);
        chk("instr", instr, data);
        chk("pc", pc, exp_addr);
        chk("opcode", 16'(opcode), 16'(exp_opc));
    endtask

    task automatic accept(input logic j, input logic b, input logic z);
        jump        = j;
        branch      = b;
        alu_zero    = z;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        alu_zero    = 1'b0;
        chk("valid_drop", 16'(instr_valid), 16'd0);
    endtask

    initial begin
        logic [15:0] exp_pc;
        int          n;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        instr_ready = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        alu_zero    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 16'(instr_valid), 16'd0);
        chk("rst_req", 16'(imem_req), 16'd0);
        chk("rst_err", 16'(fetch_err), 16'd0);
        chk("rst_pc", pc, 16'h0010);
        chk("rst_instr", instr, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        chk("first_req", 16'(imem_req), 16'd1);
        chk("first_addr", imem_addr, 16'h0010);

        exp_pc = 16'h0010;
        for (int i = 0; i < 19; i++) begin
            fetch(exp_pc, tv_instr[i], tv_waits[i]);
            if (i == 0) begin
                chk("first_opcode", 16'(opcode), 16'h0001);
                chk("pc_plus1", pc_plus1, 16'h0011);
            end
            accept(tv_jbz[i][2], tv_jbz[i][1], tv_jbz[i][0]);
            exp_pc = tv_next[i];
        end

        // Backpressure with spurious acks and decoder inputs toggling while held.
        fetch(16'h007E, 16'h1234, 0);
        jump     = 1'b1;
        branch   = 1'b1;
        alu_zero = 1'b1;
        for (int i = 0; i < 10; i++) begin
            imem_ack   = (i % 2 == 0);
            imem_rdata = 16'hBEEF;
            @(negedge clk);
            chk("bp_instr", instr, 16'h1234);
            chk("bp_valid", 16'(instr_valid), 16'd1);
            chk("bp_req", 16'(imem_req), 16'd0);
        end
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        accept(1'b0, 1'b0, 1'b0);
        chk("bp_next_addr", imem_addr, 16'h007F);

        // Watchdog: never acknowledge.
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("wd_cycles", 16'(n), 16'd16);
        chk("wd_err", 16'(fetch_err), 16'd1);
        chk("wd_req", 16'(imem_req), 16'd0);
        chk("wd_valid", 16'(instr_valid), 16'd0);
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        chk("wd_sticky", 16'(fetch_err), 16'd1);
        chk("wd_sticky_req", 16'(imem_req), 16'd0);

        // Reset out of ERR, then reset mid-FETCH with a simultaneous ack.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("err_clr", 16'(fetch_err), 16'd0);
        chk("err_clr_pc", pc, 16'h0010);
        @(negedge clk);
        chk("refetch_req", 16'(imem_req), 16'd1);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hAAAA;
        @(negedge clk);
        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        chk("rstack_valid", 16'(instr_valid), 16'd0);
        chk("rstack_instr", instr, 16'h0000);
        chk("rstack_pc", pc, 16'h0010);
        chk("rstack_err", 16'(fetch_err), 16'd0);
        fetch(16'h0010, 16'h4321, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
